rv32i_dmem_responder: RTL and testbench

- Synchronous data-memory responder for the rv32i core's load/store port.
- It is the slave end of the data bus. It accepts one strobed request at a time, applies byte-masked writes or returns read words after a programmable number of wait states, and signals completion with a one-cycle ack.
- It replaces the zero-latency data RAM so the core's stall path can be exercised against realistic memory timing.

---
 rtl/rv32i_dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dmem_responder.sv
// Wait-stated data-memory slave for the rv32i load/store port: one request at a time,
// byte-masked stores, one-cycle ack. Define DMEM_STATS_EN to add load/store counters.
module rv32i_dmem_responder #(
    parameter int RAM_DEPTH   = 8192,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stb,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_in,
    input  logic [3:0]  i_wr_mask,
    output logic        o_ack,
    output logic [31:0] o_data_out,
    output logic        o_err,
    output logic        o_busy
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] o_rd_count,
    output logic [15:0] o_wr_count
`endif
);

    localparam int          WORDS     = RAM_DEPTH / 4;
    localparam int          IDXW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] RAM_LIMIT = 32'(RAM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              accept_s;

    logic [31:0]       addr_r;
    logic [31:0]       data_r;
    logic [3:0]        mask_r;
    logic              wr_r;

    logic [31:0]       eff_addr_s;
    logic              eff_wr_s;
    logic              in_range_s;
    logic              resp_s;
    logic [IDXW-1:0]   rd_idx_s;
    logic [IDXW-1:0]   wr_idx_s;

    logic [31:0]       mem [0:WORDS-1];

    // Next-state and wait-counter logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_stb) begin
                    accept_s = 1'b1;
                    cnt_s    = 4'(WAIT_STATES);
                    state_s  = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = ST_RESP;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // The response registers are loaded on the edge entering RESP; with zero wait
    // states that is the acceptance edge, so the live inputs are used there.
    always_comb begin
        if (accept_s) begin
            eff_addr_s = i_addr;
            eff_wr_s   = i_wr_en;
        end else begin
            eff_addr_s = addr_r;
            eff_wr_s   = wr_r;
        end
        in_range_s = (eff_addr_s < RAM_LIMIT);
        resp_s     = (state_s == ST_RESP);
        rd_idx_s   = eff_addr_s[IDXW+1:2];
        wr_idx_s   = addr_r[IDXW+1:2];
    end

    // State, captured request and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= 32'h0000_0000;
            data_r     <= 32'h0000_0000;
            mask_r     <= 4'h0;
            wr_r       <= 1'b0;
            o_ack      <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b0;
            o_data_out <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                addr_r <= i_addr;
                data_r <= i_data_in;
                mask_r <= i_wr_mask;
                wr_r   <= i_wr_en;
            end
            o_ack      <= resp_s;
            o_err      <= resp_s && !in_range_s;
            o_busy     <= (state_s != ST_IDLE);
            o_data_out <= (resp_s && in_range_s && !eff_wr_s) ? mem[rd_idx_s] : 32'h0000_0000;
        end
    end

    // Store commit at the end of the RESP cycle; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_RESP) && wr_r && (addr_r < RAM_LIMIT)) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_r[b]) begin
                    mem[wr_idx_s][8*b +: 8] <= data_r[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_STATS_EN
    // Successful load/store counters, stepped on the edge that raises ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_count <= 16'h0000;
            o_wr_count <= 16'h0000;
        end else if (resp_s && in_range_s) begin
            if (eff_wr_s) begin
                o_wr_count <= o_wr_count + 16'h0001;
            end else begin
                o_rd_count <= o_rd_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Bench for rv32i_dmem_responder: directed vector table, hand-written corner sequences,
// and random traffic against a byte-lane memory model on two wait-state configurations.
module tb_rv32i_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stb;
    logic [1:0]  wr_en;
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [3:0]  mask [2];
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  busy;
    logic [31:0] dout [2];
`ifdef DMEM_STATS_EN
    logic [15:0] rd_count0, wr_count0, rd_count1, wr_count1;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    rv32i_dmem_responder #(.RAM_DEPTH(8192), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst(rst), .i_stb(stb[0]), .i_wr_en(wr_en[0]), .i_addr(addr[0]),
        .i_data_in(din[0]), .i_wr_mask(mask[0]), .o_ack(ack[0]), .o_data_out(dout[0]),
        .o_err(err[0]), .o_busy(busy[0])
`ifdef DMEM_STATS_EN
        , .o_rd_count(rd_count0), .o_wr_count(wr_count0)
`endif
    );

    rv32i_dmem_responder #(.RAM_DEPTH(8192), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_stb(stb[1]), .i_wr_en(wr_en[1]), .i_addr(addr[1]),
        .i_data_in(din[1]), .i_wr_mask(mask[1]), .o_ack(ack[1]), .o_data_out(dout[1]),
        .o_err(err[1]), .o_busy(busy[1])
`ifdef DMEM_STATS_EN
        , .o_rd_count(rd_count1), .o_wr_count(wr_count1)
`endif
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int mkey(input int s, input logic [31:0] a);
        return s * 65536 + int'(a >> 2);
    endfunction

    // One request on instance s; cyc is the ack cycle counted from the acceptance edge.
    task automatic txn(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output logic e,
                       output int cyc, output logic bsy);
        logic [31:0] w;
        @(negedge clk);
        stb[s] = 1'b1; wr_en[s] = wr; addr[s] = a; din[s] = d; mask[s] = m;
        @(posedge clk);
        #1;
        stb[s] = 1'b0; wr_en[s] = 1'($urandom); addr[s] = $urandom; din[s] = $urandom;
        mask[s] = 4'($urandom);
        cyc = -1; rd = 32'h0; e = 1'b0; bsy = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack[s]) begin
                cyc = n; rd = dout[s]; e = err[s]; bsy = busy[s];
                break;
            end
        end
        if (wr && a < 32'd8192) begin
            w = model.exists(mkey(s, a)) ? model[mkey(s, a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
            model[mkey(s, a)] = w;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd, a, d, exp_d;
        logic        e, bsy, wr, exp_e;
        logic [3:0]  m;
        int          cyc, seen, first_cyc;

        vecs[0]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_1000, 32'h0,         4'b0000, 32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_1000, 32'hAABB_CCDD, 4'b0010, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         4'b1111, 32'h1234_CC78, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_1000, 32'hAABB_CCDD, 4'b0000, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_1003, 32'h0,         4'b0000, 32'h1234_CC78, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0004, 32'h5566_7788, 4'b1111, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_2000, 32'h0,         4'b0000, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_2004, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h5566_7788, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_1FFC, 32'hCAFE_F00D, 4'b1001, 32'h0, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_1008, 32'h0102_0304, 4'b1111, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'h0, 1'b1};

        rst = 1'b1; stb = 2'b00; wr_en = 2'b00;
        for (int s = 0; s < 2; s++) begin
            addr[s] = 32'h0; din[s] = 32'h0; mask[s] = 4'h0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data0", dout[0], 32'h0);
        chk("rst_data1", dout[1], 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            txn(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, rd, e, cyc, bsy);
            chk($sformatf("vec%0d_cycle", i), 32'(cyc), 32'd2);
            chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_busy", i), 32'(bsy), 32'h1);
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy[0]), 32'h0);
        chk("idle_ack", 32'(ack[0]), 32'h0);

        // Reset during WAIT aborts the store.
        @(negedge clk);
        stb[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h1008; din[0] = 32'hDEAD_BEEF; mask[0] = 4'hF;
        @(posedge clk);
        #1 stb[0] = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", 32'(busy[0]), 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_busy_async", 32'(busy[0]), 32'h0);
        chk("midrst_ack_async", 32'(ack[0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack[0]) seen++;
        end
        chk("midrst_no_ack", 32'(seen), 32'h0);
        txn(0, 1'b0, 32'h1008, 32'h0, 4'h0, rd, e, cyc, bsy);
        chk("midrst_reload", rd, 32'h0102_0304);
        chk("midrst_reload_cycle", 32'(cyc), 32'd2);

        // Busy rejection with three wait states: B arrives two cycles after A.
        txn(1, 1'b1, 32'h0100, 32'h0BAD_F00D, 4'hF, rd, e, cyc, bsy);
        chk("ws3_store_cycle", 32'(cyc), 32'd4);
        @(negedge clk);
        stb[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = 32'h0100; mask[1] = 4'h0;
        @(posedge clk);
        #1 stb[1] = 1'b0;
        seen = 0; first_cyc = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ack[1]) begin
                seen++;
                if (first_cyc < 0) begin
                    first_cyc = n; rd = dout[1];
                end
            end
            if (n == 2) begin
                chk("ws3_busy_at_b", 32'(busy[1]), 32'h1);
                stb[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = 32'h0100; din[1] = 32'hFFFF_FFFF;
                mask[1] = 4'hF;
            end
            if (n == 3) stb[1] = 1'b0;
        end
        chk("ws3_ack_count", 32'(seen), 32'd1);
        chk("ws3_ack_cycle", 32'(first_cyc), 32'd4);
        chk("ws3_a_data", rd, 32'h0BAD_F00D);
        txn(1, 1'b0, 32'h0100, 32'h0, 4'h0, rd, e, cyc, bsy);
        chk("ws3_b_dropped", rd, 32'h0BAD_F00D);

        // Random traffic on both instances against the model.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                txn(s, 1'b1, 32'h0800 + 32'(4 * i), $urandom, 4'hF, rd, e, cyc, bsy);
            end
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 7) == 0) a = 32'h2000 + 32'($urandom_range(0, 32'h00FF_FFFF));
                else a = 32'h0800 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                wr = 1'($urandom_range(0, 1));
                d = $urandom;
                m = 4'($urandom_range(0, 15));
                exp_e = (a >= 32'd8192);
                exp_d = (!wr && !exp_e) ? model[mkey(s, a)] : 32'h0;
                txn(s, wr, a, d, m, rd, e, cyc, bsy);
                chk($sformatf("rnd%0d_%0d_cycle", s, i), 32'(cyc), (s == 0) ? 32'd2 : 32'd4);
                chk($sformatf("rnd%0d_%0d_data", s, i), rd, exp_d);
                chk($sformatf("rnd%0d_%0d_err", s, i), 32'(e), 32'(exp_e));
            end
        end

`ifdef DMEM_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, rd, e, cyc, bsy);
        txn(0, 1'b1, 32'h1FFC, 32'h1111_2222, 4'hF, rd, e, cyc, bsy);
        txn(0, 1'b0, 32'h0004, 32'h0, 4'h0, rd, e, cyc, bsy);
        txn(0, 1'b0, 32'h3000, 32'h0, 4'h0, rd, e, cyc, bsy);
        txn(0, 1'b1, 32'h0004, 32'h3333_4444, 4'h0, rd, e, cyc, bsy);
        txn(0, 1'b0, 32'h1008, 32'h0, 4'h0, rd, e, cyc, bsy);
        @(negedge clk);
        chk("stats_rd", 32'(rd_count0), 32'd3);
        chk("stats_wr", 32'(wr_count0), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("stats_rd_rst", 32'(rd_count0), 32'd0);
        chk("stats_wr_rst", 32'(wr_count0), 32'd0);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
